// File: rtl/char_pkg.sv
// Shared definitions for the character life controller: game-state
// encodings, Event bus bit positions and a counter-width helper.
package char_pkg;

    typedef enum logic [1:0] {
        GS_IDLE = 2'd0,
        GS_PLAY = 2'd1,
        GS_OVER = 2'd2
    } game_state_t;

    // Bit positions on the Event bus {d_die, d1_die, d2_die, r_die}
    localparam int EV_D  = 3;
    localparam int EV_D1 = 2;
    localparam int EV_D2 = 1;
    localparam int EV_R  = 0;

    localparam int SCORE_W = 14;

    // Width of a down-counter that must hold values 0 .. cyc-1
    function automatic int cnt_width(input int cyc);
        return (cyc > 2) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/char_life_ctrl_respawn_timer.sv
// Per-character alive flag plus respawn countdown. A kill while alive hides
// the character and loads CYC-1; the flag comes back on the edge the
// countdown is found at zero, i.e. CYC edges after the kill.
module respawn_timer
    import char_pkg::*;
#(
    parameter int CYC = 25000000,
    parameter int TW  = cnt_width(CYC)
) (
    input  logic          clk_25Hz,
    input  logic          rst,
    input  logic          kill,
    input  logic          clear,
    input  logic          enable,
    output logic          valid,
    output logic [TW-1:0] timer
);

    localparam logic [TW-1:0] RELOAD = TW'(CYC - 1);

    logic          valid_q, valid_d;
    logic [TW-1:0] timer_q, timer_d;

    // Next-state: clear (game (re)start) wins, disabled means hidden and idle
    always_comb begin
        valid_d = valid_q;
        timer_d = timer_q;
        if (clear) begin
            valid_d = 1'b1;
            timer_d = '0;
        end else if (!enable) begin
            valid_d = 1'b0;
            timer_d = '0;
        end else if (valid_q) begin
            if (kill) begin
                valid_d = 1'b0;
                timer_d = RELOAD;
            end
        end else if (timer_q == '0) begin
            valid_d = 1'b1;
        end else begin
            timer_d = timer_q - TW'(1);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_25Hz or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            timer_q <= '0;
        end else begin
            valid_q <= valid_d;
            timer_q <= timer_d;
        end
    end

    assign valid = valid_q;
    assign timer = timer_q;

endmodule

// File: rtl/char_life_ctrl.sv
// Game-state controller behind the sprite renderer's Event bus: rising-edge
// detection of death events, per-character respawn timers, saturating score,
// robot lives and the IDLE/PLAY/OVER sequence.
module char_life_ctrl
    import char_pkg::*;
#(
    parameter int LIVES     = 3,
    parameter int D_RESPAWN = 25000000,
    parameter int R_RESPAWN = 50000000,
    parameter int SCORE_MAX = 9999
) (
    input  logic                clk_25Hz,
    input  logic                rst,
    input  logic [3:0]          Event,
    input  logic                start,
    output logic                d_valid,
    output logic                d1_valid,
    output logic                d2_valid,
    output logic                r_valid,
    output logic [SCORE_W-1:0]  score,
    output logic [1:0]          lives,
    output logic [1:0]          game_state
);

    localparam int DTW = cnt_width(D_RESPAWN);
    localparam int RTW = cnt_width(R_RESPAWN);
    localparam logic [SCORE_W-1:0] SCORE_CAP  = SCORE_W'(SCORE_MAX);
    localparam logic [1:0]         LIVES_INIT = 2'(LIVES);

    game_state_t        state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic [3:0]         ev_q;

    logic [3:0]         new_ev;
    logic [3:0]         alive;
    logic [3:0]         hits;
    logic [1:0]         kill_cnt;
    logic [SCORE_W:0]   score_sum;
    logic               go_over;
    logic               tmr_enable;

    logic [DTW-1:0]     d_tmr [1:3];
    logic [RTW-1:0]     r_tmr;

    // Edge detect, score adder/clamp, lives counter and game-state sequencing
    always_comb begin
        new_ev     = Event & ~ev_q;
        hits       = new_ev & alive;
        kill_cnt   = 2'(hits[EV_D]) + 2'(hits[EV_D1]) + 2'(hits[EV_D2]);
        score_sum  = {1'b0, score_q} + (SCORE_W + 1)'(kill_cnt);
        go_over    = (state_q == GS_PLAY) && !start && hits[EV_R] && (lives_q == 2'd1);
        tmr_enable = (state_q == GS_PLAY) && !go_over;

        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        if (start) begin
            state_d = GS_PLAY;
            score_d = '0;
            lives_d = LIVES_INIT;
        end else if (state_q == GS_PLAY) begin
            score_d = (score_sum > {1'b0, SCORE_CAP}) ? SCORE_CAP : score_sum[SCORE_W-1:0];
            if (hits[EV_R]) begin
                lives_d = lives_q - 2'd1;
                if (go_over) begin
                    state_d = GS_OVER;
                end
            end
        end
    end

    // Top FSM and bookkeeping registers; ev_q tracks Event in every state
    always_ff @(posedge clk_25Hz or negedge rst) begin
        if (!rst) begin
            state_q <= GS_IDLE;
            score_q <= '0;
            lives_q <= LIVES_INIT;
            ev_q    <= '0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            lives_q <= lives_d;
            ev_q    <= Event;
        end
    end

    // One respawn timer per dragon, indexed by its Event bit
    generate
        for (genvar gi = EV_D2; gi <= EV_D; gi++) begin : g_dragon
            respawn_timer #(
                .CYC (D_RESPAWN),
                .TW  (DTW)
            ) u_tmr (
                .clk_25Hz (clk_25Hz),
                .rst      (rst),
                .kill     (new_ev[gi]),
                .clear    (start),
                .enable   (tmr_enable),
                .valid    (alive[gi]),
                .timer    (d_tmr[gi])
            );
        end
    endgenerate

    respawn_timer #(
        .CYC (R_RESPAWN),
        .TW  (RTW)
    ) u_robot_tmr (
        .clk_25Hz (clk_25Hz),
        .rst      (rst),
        .kill     (new_ev[EV_R]),
        .clear    (start),
        .enable   (tmr_enable),
        .valid    (alive[EV_R]),
        .timer    (r_tmr)
    );

    // Outside PLAY no countdown may be pending
    timers_idle_zero: assert property (@(posedge clk_25Hz) disable iff (!rst)
        (state_q != GS_PLAY) |->
        ((d_tmr[1] == '0) && (d_tmr[2] == '0) && (d_tmr[3] == '0) && (r_tmr == '0)));

    assign d_valid    = alive[EV_D];
    assign d1_valid   = alive[EV_D1];
    assign d2_valid   = alive[EV_D2];
    assign r_valid    = alive[EV_R];
    assign score      = score_q;
    assign lives      = lives_q;
    assign game_state = state_q;

endmodule

// File: tb/tb_char_life_ctrl.sv
// Directed bench for char_life_ctrl with short respawn times
// (D_RESPAWN=8, R_RESPAWN=16, LIVES=3).
module tb_char_life_ctrl;

    logic        clk_25Hz;
    logic        rst;
    logic [3:0]  Event;
    logic        start;
    logic        d_valid, d1_valid, d2_valid, r_valid;
    logic [13:0] score;
    logic [1:0]  lives;
    logic [1:0]  game_state;

    int n_checks = 0;
    int n_fail   = 0;

    char_life_ctrl #(
        .LIVES     (3),
        .D_RESPAWN (8),
        .R_RESPAWN (16),
        .SCORE_MAX (9999)
    ) dut (
        .clk_25Hz   (clk_25Hz),
        .rst        (rst),
        .Event      (Event),
        .start      (start),
        .d_valid    (d_valid),
        .d1_valid   (d1_valid),
        .d2_valid   (d2_valid),
        .r_valid    (r_valid),
        .score      (score),
        .lives      (lives),
        .game_state (game_state)
    );

    initial begin
        clk_25Hz = 1'b0;
        forever #5 clk_25Hz = ~clk_25Hz;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_25Hz);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [15:0] vals();
        return {12'd0, d_valid, d1_valid, d2_valid, r_valid};
    endfunction

    initial begin
        rst   = 1'b0;
        Event = 4'b0000;
        start = 1'b0;
        #12;
        // Reset values while rst held low
        check("rst_valids", vals(), 16'd0);
        check("rst_score",  16'(score), 16'd0);
        check("rst_lives",  16'(lives), 16'd3);
        check("rst_state",  16'(game_state), 16'd0);
        tick(1);
        rst = 1'b1;
        tick(2);
        check("idle_valids", vals(), 16'd0);

        // Start -> PLAY on the next edge
        start = 1'b1; tick(1); start = 1'b0;
        check("start_state",  16'(game_state), 16'd1);
        check("start_valids", vals(), 16'b1111);
        check("start_score",  16'(score), 16'd0);
        check("start_lives",  16'(lives), 16'd3);

        // Event=1000 held 100 cycles: one kill, respawn 8 edges later
        Event = 4'b1000; tick(1);
        check("d_kill_valid", 16'(d_valid), 16'd0);
        check("d_kill_score", 16'(score), 16'd1);
        tick(7);
        check("d_dead_at7", 16'(d_valid), 16'd0);
        tick(1);
        check("d_back_at8", 16'(d_valid), 16'd1);
        tick(91);
        check("d_held_score", 16'(score), 16'd1);
        check("d_held_valid", 16'(d_valid), 16'd1);
        Event = 4'b0000; tick(1);

        // 0100 then 0110: only d2 is new on the second step
        Event = 4'b0100; tick(1);
        check("d1_kill_vals",  vals(), 16'b1011);
        check("d1_kill_score", 16'(score), 16'd2);
        Event = 4'b0110; tick(1);
        check("d2_kill_vals",  vals(), 16'b1001);
        check("d2_kill_score", 16'(score), 16'd3);
        Event = 4'b0000; tick(10);
        check("d12_back_vals", vals(), 16'b1111);

        // All four at once
        Event = 4'b1111; tick(1);
        check("all_kill_vals",  vals(), 16'b0000);
        check("all_kill_score", 16'(score), 16'd6);
        check("all_kill_lives", 16'(lives), 16'd2);
        Event = 4'b0000; tick(7);
        check("all_at7",  vals(), 16'b0000);
        tick(1);
        check("all_at8",  vals(), 16'b1110);
        tick(7);
        check("all_at15", vals(), 16'b1110);
        tick(1);
        check("all_at16", vals(), 16'b1111);

        // Restart during PLAY
        start = 1'b1; tick(1); start = 1'b0;
        check("rs_score", 16'(score), 16'd0);
        check("rs_lives", 16'(lives), 16'd3);

        // Three robot hits separated by respawns
        Event = 4'b0001; tick(1);
        check("r1_lives", 16'(lives), 16'd2);
        check("r1_vals",  vals(), 16'b1110);
        Event = 4'b0000; tick(16);
        check("r1_back",  vals(), 16'b1111);
        Event = 4'b0001; tick(1);
        check("r2_lives", 16'(lives), 16'd1);
        Event = 4'b0000; tick(16);
        Event = 4'b0001; tick(1);
        check("r3_lives", 16'(lives), 16'd0);
        check("r3_state", 16'(game_state), 16'd2);
        check("r3_vals",  vals(), 16'b0000);
        Event = 4'b0000; tick(1);
        Event = 4'b1110; tick(1);
        check("over_score", 16'(score), 16'd0);
        check("over_vals",  vals(), 16'b0000);
        check("over_state", 16'(game_state), 16'd2);
        Event = 4'b0000;
        start = 1'b1; tick(1); start = 1'b0;
        check("ov_st_state", 16'(game_state), 16'd1);
        check("ov_st_lives", 16'(lives), 16'd3);
        check("ov_st_vals",  vals(), 16'b1111);

        // Score saturation from a preloaded value
        Event = 4'b1110;
        force dut.score_q = 14'd9998;
        #1;
        release dut.score_q;
        check("sat_preload", 16'(score), 16'd9998);
        tick(1);
        check("sat_score", 16'(score), 16'd9999);
        check("sat_vals",  vals(), 16'b0001);
        Event = 4'b0000; tick(3);
        check("mid_count", vals(), 16'b0001);

        // Asynchronous reset mid-countdown
        #2 rst = 1'b0;
        #1;
        check("arst_vals",  vals(), 16'd0);
        check("arst_score", 16'(score), 16'd0);
        check("arst_lives", 16'(lives), 16'd3);
        check("arst_state", 16'(game_state), 16'd0);
        tick(2);
        rst = 1'b1;
        tick(10);
        check("post_rst_vals",  vals(), 16'd0);
        check("post_rst_state", 16'(game_state), 16'd0);
        start = 1'b1; tick(1); start = 1'b0;
        check("final_vals", vals(), 16'b1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
